tap_controller: RTL and testbench

IEEE 1149.1-style Test Access Port controller that drives the boundary-scan cell chain. It decodes TMS into the 16-state TAP state machine, holds the instruction register and the internal BYPASS and IDCODE data registers, and issues CaptureDR/ShiftDR/UpdateDR to the boundary-scan cells. It also selects what appears on TDO, and sits between the chip's JTAG pins and the first and last cells of the boundary-scan register (BSR).

---
 rtl/tap_controller.sv | 140 ++++++++++++++
 tb/tb_tap_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state TMS FSM, IR, BYPASS and IDCODE registers,
// boundary-scan strobes and TDO selection between the JTAG pins and the BSR ends.
module tap_controller #(
    parameter int unsigned IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    output logic       TDO,
    output logic       TDOEnable,
    input  logic       BSRIn,
    output logic       BSROut,
    output logic       CaptureDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic       ExtestMode,
    output logic [3:0] TapState
);

    typedef enum logic [3:0] {
        StTlr     = 4'hF,
        StRti     = 4'hC,
        StSelDr   = 4'h7,
        StCapDr   = 4'h6,
        StShDr    = 4'h2,
        StEx1Dr   = 4'h1,
        StPauseDr = 4'h3,
        StEx2Dr   = 4'h0,
        StUpdDr   = 4'h5,
        StSelIr   = 4'h4,
        StCapIr   = 4'hE,
        StShIr    = 4'hA,
        StEx1Ir   = 4'h9,
        StPauseIr = 4'hB,
        StEx2Ir   = 4'h8,
        StUpdIr   = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IrExtest  = '0;
    localparam logic [IR_WIDTH-1:0] IrSample  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IrIdcode  = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(1);

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic                bypass_q;
    logic [31:0]         idcode_q;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q;
    logic                sel_bsr, sel_idcode, sel_bypass;

    // Unassigned codes fall through to BYPASS.
    assign sel_bsr    = (ir_q == IrExtest) || (ir_q == IrSample);
    assign sel_idcode = (ir_q == IrIdcode);
    assign sel_bypass = !sel_bsr && !sel_idcode;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:     state_d = TMS ? StTlr     : StRti;
            StRti:     state_d = TMS ? StSelDr   : StRti;
            StSelDr:   state_d = TMS ? StSelIr   : StCapDr;
            StCapDr:   state_d = TMS ? StEx1Dr   : StShDr;
            StShDr:    state_d = TMS ? StEx1Dr   : StShDr;
            StEx1Dr:   state_d = TMS ? StUpdDr   : StPauseDr;
            StPauseDr: state_d = TMS ? StEx2Dr   : StPauseDr;
            StEx2Dr:   state_d = TMS ? StUpdDr   : StShDr;
            StUpdDr:   state_d = TMS ? StSelDr   : StRti;
            StSelIr:   state_d = TMS ? StTlr     : StCapIr;
            StCapIr:   state_d = TMS ? StEx1Ir   : StShIr;
            StShIr:    state_d = TMS ? StEx1Ir   : StShIr;
            StEx1Ir:   state_d = TMS ? StUpdIr   : StPauseIr;
            StPauseIr: state_d = TMS ? StEx2Ir   : StPauseIr;
            StEx2Ir:   state_d = TMS ? StUpdIr   : StShIr;
            StUpdIr:   state_d = TMS ? StSelDr   : StRti;
            default:   state_d = StTlr;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q    <= StTlr;
            ir_q       <= IrIdcode;
            ir_shift_q <= IrCapture;
            bypass_q   <= 1'b0;
            idcode_q   <= IDCODE_VALUE;
        end else begin
            state_q <= state_d;
            case (state_q)
                StTlr:   ir_q <= IrIdcode;
                StCapIr: ir_shift_q <= IrCapture;
                StShIr:  ir_shift_q <= {TDI, ir_shift_q[IR_WIDTH-1:1]};
                StUpdIr: ir_q <= ir_shift_q;
                StCapDr: begin
                    if (sel_bypass) bypass_q <= 1'b0;
                    if (sel_idcode) idcode_q <= IDCODE_VALUE;
                end
                StShDr: begin
                    if (sel_bypass) bypass_q <= TDI;
                    if (sel_idcode) idcode_q <= {TDI, idcode_q[31:1]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tdo_d = 1'b0;
        if (state_q == StShIr) begin
            tdo_d = ir_shift_q[0];
        end else if (state_q == StShDr) begin
            if (sel_idcode)      tdo_d = idcode_q[0];
            else if (sel_bypass) tdo_d = bypass_q;
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= (state_q == StShDr) || (state_q == StShIr);
        end
    end

    // The last BS cell already launches on negedge, so BSRIn bypasses the TDO flop.
    assign TDO        = ((state_q == StShDr) && sel_bsr) ? BSRIn : tdo_q;
    assign TDOEnable  = tdo_en_q;
    assign BSROut     = TDI;
    assign CaptureDR  = sel_bsr && (state_q == StCapDr);
    assign ShiftDR    = sel_bsr && (state_q == StShDr);
    assign UpdateDR   = sel_bsr && (state_q == StUpdDr);
    assign ExtestMode = (ir_q == IrExtest);
    assign TapState   = state_q;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: reset, IDCODE/BYPASS/EXTEST scans, state sweep, TRST mid-scan.
module tb_tap_controller;

    localparam logic [31:0] IdVal = 32'h1000_0001;

    logic       TCK = 1'b0;
    logic       TRST, TMS, TDI, BSRIn;
    logic       TDO, TDOEnable, BSROut, CaptureDR, ShiftDR, UpdateDR, ExtestMode;
    logic [3:0] TapState;

    int nvec = 0;
    int nerr = 0;
    int cap_cnt, sh_cnt, upd_cnt, en_cnt;

    tap_controller #(
        .IR_WIDTH    (4),
        .IDCODE_VALUE(IdVal)
    ) dut (
        .TCK       (TCK),
        .TRST      (TRST),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .TDOEnable (TDOEnable),
        .BSRIn     (BSRIn),
        .BSROut    (BSROut),
        .CaptureDR (CaptureDR),
        .ShiftDR   (ShiftDR),
        .UpdateDR  (UpdateDR),
        .ExtestMode(ExtestMode),
        .TapState  (TapState)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One TCK: drive, take the posedge, sample just after the following negedge.
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
        cap_cnt += int'(CaptureDR);
        sh_cnt  += int'(ShiftDR);
        upd_cnt += int'(UpdateDR);
        en_cnt  += int'(TDOEnable);
    endtask

    task automatic clr_cnt();
        cap_cnt = 0;
        sh_cnt  = 0;
        upd_cnt = 0;
        en_cnt  = 0;
    endtask

    task automatic to_rti();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI back to RTI; dout collects TDO seen in ShIR, LSB first.
    task automatic ir_scan(input logic [3:0] code, output logic [3:0] dout);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dout[i] = TDO;
            step(i == 3, code[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // TMS paths from TLR (LSB first) to every state, with the state code reached.
    int         path_len [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [7:0] path_bits[16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                                  8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
    logic [3:0] path_st  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                                  4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

    initial begin
        logic [31:0] dout;
        logic [3:0]  irout;
        logic [7:0]  pb;

        TRST  = 1'b0;
        TMS   = 1'b1;
        TDI   = 1'b0;
        BSRIn = 1'b0;
        clr_cnt();
        step(1'b1, 1'b0);
        check("rst_state", 32'(TapState), 32'hF);
        check("rst_tdoen", 32'(TDOEnable), 32'h0);
        check("rst_tdo", 32'(TDO), 32'h0);
        check("rst_strobes", 32'({CaptureDR, ShiftDR, UpdateDR}), 32'h0);
        check("rst_extest", 32'(ExtestMode), 32'h0);
        TRST = 1'b1;

        // IDCODE is the default instruction after reset.
        to_rti();
        check("rti_state", 32'(TapState), 32'hC);
        clr_cnt();
        dr_scan(32, 32'h0, dout);
        check("idcode_value", dout, IdVal);
        check("idcode_bit0", 32'(dout[0]), 32'h1);
        check("idcode_tdoen_cnt", 32'(en_cnt), 32'd32);
        check("idcode_strobes", 32'(cap_cnt + sh_cnt + upd_cnt), 32'd0);
        check("idcode_end_tdoen", 32'(TDOEnable), 32'h0);

        // BYPASS: captured 0 then TDI delayed one bit.
        ir_scan(4'b1111, irout);
        check("ir_capture_bypass", 32'(irout), 32'h1);
        check("bypass_extest", 32'(ExtestMode), 32'h0);
        clr_cnt();
        dr_scan(9, 32'h0A5, dout);
        check("bypass_data", dout, 32'h14A);
        check("bypass_strobes", 32'(cap_cnt + sh_cnt + upd_cnt), 32'd0);

        // Unassigned code behaves as BYPASS.
        ir_scan(4'b0101, irout);
        dr_scan(3, 32'h3, dout);
        check("undef_bypass", dout, 32'h6);

        // EXTEST with BSRIn forced high; TDO passes it straight through.
        ir_scan(4'b0000, irout);
        check("ir_capture_extest", 32'(irout), 32'h1);
        check("extest_mode", 32'(ExtestMode), 32'h1);
        BSRIn = 1'b1;
        clr_cnt();
        dr_scan(4, 32'h5, dout);
        check("extest_tdo", dout, 32'hF);
        check("extest_cap_cnt", 32'(cap_cnt), 32'd1);
        check("extest_sh_cnt", 32'(sh_cnt), 32'd4);
        check("extest_upd_cnt", 32'(upd_cnt), 32'd1);
        BSRIn = 1'b0;
        TDI = 1'b1;
        #1;
        check("bsrout_hi", 32'(BSROut), 32'h1);
        TDI = 1'b0;
        #1;
        check("bsrout_lo", 32'(BSROut), 32'h0);

        // SAMPLE/PRELOAD also drives the BS cells.
        ir_scan(4'b0001, irout);
        check("sample_extest", 32'(ExtestMode), 32'h0);
        clr_cnt();
        dr_scan(2, 32'h0, dout);
        check("sample_sh_cnt", 32'(sh_cnt), 32'd2);

        // Five TMS=1 from every state lands in TLR.
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
            pb = path_bits[s];
            for (int i = 0; i < path_len[s]; i++) step(pb[i], 1'b0);
            check($sformatf("reach_%0d", s), 32'(TapState), 32'(path_st[s]));
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
            check($sformatf("tlr_from_%0d", s), 32'(TapState), 32'hF);
        end

        // TRST mid IDCODE scan.
        to_rti();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("midscan_tdoen", 32'(TDOEnable), 32'h1);
        clr_cnt();
        TRST = 1'b0;
        #1;
        check("trst_state", 32'(TapState), 32'hF);
        check("trst_tdo", 32'(TDO), 32'h0);
        check("trst_tdoen", 32'(TDOEnable), 32'h0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("trst_no_update", 32'(upd_cnt), 32'd0);
        TRST = 1'b1;

        // TRST mid IR shift discards the partial IR.
        to_rti();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        TRST = 1'b0;
        #1;
        check("trst_ir_state", 32'(TapState), 32'hF);
        step(1'b1, 1'b0);
        TRST = 1'b1;
        to_rti();
        check("trst_ir_extest", 32'(ExtestMode), 32'h0);
        dr_scan(32, 32'h0, dout);
        check("trst_ir_idcode", dout, IdVal);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
